// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared 16-bit memory port.
// Data accesses win ties. Instruction fetches are guaranteed a grant after
// at most starve_limit consecutive data grants issued while they wait.
// A grant is held until the slave acks. One idle turnaround cycle follows
// every completed or abandoned transfer.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   GRANT_NONE  | port idle, arbitration decision taken this cycle
//   GRANT_INSTR | instruction master owns the port until q_m_ack
//   GRANT_DATA  | data master owns the port until q_m_ack
module mem_arbiter #(
    parameter int unsigned starve_limit = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic [18:0] data_m_addr,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    output logic [18:0] q_m_addr,
    output logic [15:0] q_m_data_out,
    output logic        q_m_access,
    output logic        q_m_wr_en,
    output logic [1:0]  q_m_bytesel,
    input  logic        q_m_ack,
    input  logic [15:0] q_m_data_in
);

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_INSTR = 2'd1,
        GRANT_DATA  = 2'd2
    } grant_e;

    localparam logic [3:0] LIMIT = 4'(starve_limit);

    grant_e     grant_q, grant_d;
    logic [3:0] streak_q, streak_d;

    // Grant and starvation counter registers; reset aborts any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q  <= GRANT_NONE;
            streak_q <= 4'd0;
        end else begin
            grant_q  <= grant_d;
            streak_q <= streak_d;
        end
    end

    // Arbitration in idle; release of the port on ack or on a dropped request.
    always_comb begin
        grant_d  = grant_q;
        streak_d = streak_q;
        case (grant_q)
            GRANT_NONE: begin
                if (data_m_access && instr_m_access) begin
                    if (streak_q == LIMIT) begin
                        grant_d  = GRANT_INSTR;
                        streak_d = 4'd0;
                    end else begin
                        grant_d  = GRANT_DATA;
                        streak_d = (streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1;
                    end
                end else if (data_m_access) begin
                    grant_d  = GRANT_DATA;
                    streak_d = 4'd0;
                end else if (instr_m_access) begin
                    grant_d  = GRANT_INSTR;
                    streak_d = 4'd0;
                end
            end
            // A master that drops access without an ack is abandoned; the
            // counter is left alone because no new decision was made.
            GRANT_INSTR: begin
                if (q_m_ack || !instr_m_access) begin
                    grant_d = GRANT_NONE;
                end
            end
            GRANT_DATA: begin
                if (q_m_ack || !data_m_access) begin
                    grant_d = GRANT_NONE;
                end
            end
            default: begin
                grant_d = GRANT_NONE;
            end
        endcase
    end

    // Downstream port mux; instruction fetches are always full-word reads.
    always_comb begin
        q_m_addr     = 19'd0;
        q_m_data_out = 16'd0;
        q_m_access   = 1'b0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = 2'b00;
        case (grant_q)
            GRANT_DATA: begin
                q_m_addr     = data_m_addr;
                q_m_data_out = data_m_data_out;
                q_m_access   = data_m_access;
                q_m_wr_en    = data_m_wr_en;
                q_m_bytesel  = data_m_bytesel;
            end
            GRANT_INSTR: begin
                q_m_addr     = instr_m_addr;
                q_m_access   = instr_m_access;
                q_m_bytesel  = 2'b11;
            end
            default: begin
            end
        endcase
    end

    // Acks go only to the owner; a stray ack while idle reaches nobody.
    assign instr_m_ack = q_m_ack & (grant_q == GRANT_INSTR);
    assign data_m_ack  = q_m_ack & (grant_q == GRANT_DATA);

    // Read data is shared; forced low during reset so every output is quiet.
    assign instr_m_data_in = reset ? 16'd0 : q_m_data_in;
    assign data_m_data_in  = reset ? 16'd0 : q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, then hand-written
// sequences for starvation, pending requests, reset abort and stray acks.
// A behavioural slave pops the expected transaction at each ack it issues.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [18:0] instr_m_addr;
    logic        instr_m_access;
    logic        instr_m_ack;
    logic [15:0] instr_m_data_in;
    logic [18:0] data_m_addr;
    logic [15:0] data_m_data_out;
    logic        data_m_access;
    logic        data_m_wr_en;
    logic [1:0]  data_m_bytesel;
    logic        data_m_ack;
    logic [15:0] data_m_data_in;
    logic [18:0] q_m_addr;
    logic [15:0] q_m_data_out;
    logic        q_m_access;
    logic        q_m_wr_en;
    logic [1:0]  q_m_bytesel;
    logic        q_m_ack;
    logic [15:0] q_m_data_in;

    mem_arbiter #(.starve_limit(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_m_addr    (instr_m_addr),
        .instr_m_access  (instr_m_access),
        .instr_m_ack     (instr_m_ack),
        .instr_m_data_in (instr_m_data_in),
        .data_m_addr     (data_m_addr),
        .data_m_data_out (data_m_data_out),
        .data_m_access   (data_m_access),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_bytesel  (data_m_bytesel),
        .data_m_ack      (data_m_ack),
        .data_m_data_in  (data_m_data_in),
        .q_m_addr        (q_m_addr),
        .q_m_data_out    (q_m_data_out),
        .q_m_access      (q_m_access),
        .q_m_wr_en       (q_m_wr_en),
        .q_m_bytesel     (q_m_bytesel),
        .q_m_ack         (q_m_ack),
        .q_m_data_in     (q_m_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic        wr;
        logic [1:0]  bsel;
        logic [15:0] rdata;
        logic        exp_wr;
        logic [1:0]  exp_bsel;
        logic [15:0] exp_dout;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic [18:0] addr;
        logic        exp_wr;
        logic [1:0]  exp_bsel;
        logic [15:0] exp_dout;
        logic [15:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int slave_lat = 1;
    bit slave_on = 1'b1;
    bit ack_pending = 1'b0;
    bit data_auto = 1'b0;
    bit instr_auto = 1'b0;
    int data_left = 0;
    int instr_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave: acks after slave_lat cycles of access, checks the port against
    // the head of the expected queue, then lets the acked master move on.
    task automatic slave_loop();
        txn_t t;
        int   cnt = 0;
        bit   acked_data = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                ack_pending = 1'b0;
                q_m_ack = 1'b0;
            end else if (!slave_on) begin
                cnt = 0;
            end else if (ack_pending) begin
                q_m_ack = 1'b0;
                ack_pending = 1'b0;
                cnt = 0;
                if (acked_data) begin
                    if (data_auto && data_left > 0) begin
                        data_left--;
                        data_m_addr = data_m_addr + 19'd1;
                    end else begin
                        data_m_access = 1'b0;
                    end
                end else begin
                    if (instr_auto && instr_left > 0) begin
                        instr_left--;
                        instr_m_addr = instr_m_addr + 19'd1;
                    end else begin
                        instr_m_access = 1'b0;
                    end
                end
            end else if (q_m_access) begin
                if (cnt >= slave_lat) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected access: addr 0x%0h, expected none", q_m_addr);
                        q_m_ack = 1'b1;
                        ack_pending = 1'b1;
                        #1;
                        acked_data = data_m_ack;
                    end else begin
                        t = exp_q.pop_front();
                        check("q_m_addr", 32'(q_m_addr), 32'(t.addr));
                        check("q_m_wr_en", 32'(q_m_wr_en), 32'(t.exp_wr));
                        check("q_m_bytesel", 32'(q_m_bytesel), 32'(t.exp_bsel));
                        check("q_m_data_out", 32'(q_m_data_out), 32'(t.exp_dout));
                        q_m_data_in = t.rdata;
                        q_m_ack = 1'b1;
                        ack_pending = 1'b1;
                        #1;
                        check("data_m_ack", 32'(data_m_ack), 32'(t.is_data));
                        check("instr_m_ack", 32'(instr_m_ack), 32'(!t.is_data));
                        check("read data", 32'(t.is_data ? data_m_data_in : instr_m_data_in),
                              32'(t.rdata));
                        acked_data = data_m_ack;
                    end
                    done_cnt++;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(name, 32'(done_cnt), 32'(target));
    endtask

    task automatic push_txn(input logic is_data, input logic [18:0] addr, input logic wr,
                            input logic [1:0] bsel, input logic [15:0] dout,
                            input logic [15:0] rdata);
        txn_t t;
        t.is_data  = is_data;
        t.addr     = addr;
        t.exp_wr   = wr;
        t.exp_bsel = bsel;
        t.exp_dout = dout;
        t.rdata    = rdata;
        exp_q.push_back(t);
    endtask

    task automatic apply(input vec_t v);
        int base;
        @(posedge clk);
        #2;
        push_txn(v.is_data, v.addr, v.exp_wr, v.exp_bsel, v.exp_dout, v.rdata);
        base = done_cnt;
        data_m_data_out = v.wdata;
        data_m_wr_en    = v.wr;
        data_m_bytesel  = v.bsel;
        if (v.is_data) begin
            data_m_addr   = v.addr;
            data_m_access = 1'b1;
        end else begin
            data_m_addr    = ~v.addr;
            instr_m_addr   = v.addr;
            instr_m_access = 1'b1;
        end
        #1;
        check("access before grant", 32'(q_m_access), 32'd0);
        @(posedge clk);
        #1;
        check("grant latency", 32'(q_m_access), 32'd1);
        wait_done(base + 1, "transfer done");
        @(posedge clk);
        #1;
        check("ack single cycle", 32'(instr_m_ack | data_m_ack), 32'd0);
        check("turnaround idle", 32'(q_m_access), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        // is_data, addr, wdata, wr, bsel, rdata, exp_wr, exp_bsel, exp_dout
        vecs[0] = '{1'b0, 19'h00100, 16'hDEAD, 1'b1, 2'b01, 16'hBEEF, 1'b0, 2'b11, 16'h0000};
        vecs[1] = '{1'b1, 19'h12345, 16'hA55A, 1'b1, 2'b01, 16'h0F0F, 1'b1, 2'b01, 16'hA55A};
        vecs[2] = '{1'b1, 19'h7FFFF, 16'h0000, 1'b0, 2'b10, 16'h1234, 1'b0, 2'b10, 16'h0000};
        vecs[3] = '{1'b0, 19'h7FFFF, 16'h5555, 1'b0, 2'b00, 16'hFFFF, 1'b0, 2'b11, 16'h0000};
        vecs[4] = '{1'b1, 19'h00000, 16'hFFFF, 1'b1, 2'b11, 16'h8001, 1'b1, 2'b11, 16'hFFFF};

        reset = 1'b1;
        instr_m_addr = '0;
        instr_m_access = 1'b0;
        data_m_addr = '0;
        data_m_data_out = '0;
        data_m_access = 1'b0;
        data_m_wr_en = 1'b0;
        data_m_bytesel = '0;
        q_m_ack = 1'b0;
        q_m_data_in = 16'hABCD;

        fork
            slave_loop();
        join_none

        #12;
        check("reset q_m_access", 32'(q_m_access), 32'd0);
        check("reset q_m_addr", 32'(q_m_addr), 32'd0);
        check("reset q_m_bytesel", 32'(q_m_bytesel), 32'd0);
        check("reset instr_m_data_in", 32'(instr_m_data_in), 32'd0);
        check("reset data_m_data_in", 32'(data_m_data_in), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            apply(vecs[i]);
        end

        // Both masters request continuously: expect D,D,D,D,I,D,D,D,D,I.
        slave_lat = 0;
        for (int k = 0, di = 0, ii = 0; k < 10; k++) begin
            if (k % 5 != 4) begin
                push_txn(1'b1, 19'h20000 + 19'(di), 1'b0, 2'b11, 16'h1234, 16'hC000 + 16'(k));
                di++;
            end else begin
                push_txn(1'b0, 19'h01000 + 19'(ii), 1'b0, 2'b11, 16'h0000, 16'hC000 + 16'(k));
                ii++;
            end
        end
        @(posedge clk);
        #2;
        base = done_cnt;
        data_m_addr = 19'h20000;
        data_m_data_out = 16'h1234;
        data_m_wr_en = 1'b0;
        data_m_bytesel = 2'b11;
        data_auto = 1'b1;
        data_left = 7;
        instr_m_addr = 19'h01000;
        instr_auto = 1'b1;
        instr_left = 1;
        data_m_access = 1'b1;
        instr_m_access = 1'b1;
        wait_done(base + 10, "starvation sequence done");
        check("starvation queue drained", 32'(exp_q.size()), 32'd0);
        data_auto = 1'b0;
        instr_auto = 1'b0;
        repeat (3) @(posedge clk);

        // Instruction request arrives while a slow data write is in flight.
        slave_lat = 5;
        push_txn(1'b1, 19'h0AAAA, 1'b1, 2'b10, 16'h5A5A, 16'h0001);
        push_txn(1'b0, 19'h05555, 1'b0, 2'b11, 16'h0000, 16'h0002);
        @(posedge clk);
        #2;
        base = done_cnt;
        data_m_addr = 19'h0AAAA;
        data_m_data_out = 16'h5A5A;
        data_m_wr_en = 1'b1;
        data_m_bytesel = 2'b10;
        data_m_access = 1'b1;
        @(posedge clk);
        #1;
        check("pending: data granted", 32'(q_m_access), 32'd1);
        @(posedge clk);
        #2;
        instr_m_addr = 19'h05555;
        instr_m_access = 1'b1;
        @(posedge clk);
        #1;
        check("pending: grant held by data", 32'(q_m_addr), 32'h0AAAA);
        wait_done(base + 1, "pending: data done");
        @(posedge clk);
        #1;
        check("pending: turnaround idle", 32'(q_m_access), 32'd0);
        @(posedge clk);
        #1;
        check("pending: instr granted", 32'(q_m_access), 32'd1);
        check("pending: instr addr", 32'(q_m_addr), 32'h05555);
        wait_done(base + 2, "pending: instr done");
        repeat (3) @(posedge clk);

        // Reset in the middle of a transfer, request kept pending.
        slave_lat = 10;
        push_txn(1'b1, 19'h03C3C, 1'b0, 2'b11, 16'h0000, 16'h9999);
        @(posedge clk);
        #2;
        data_m_addr = 19'h03C3C;
        data_m_data_out = 16'h0000;
        data_m_wr_en = 1'b0;
        data_m_bytesel = 2'b11;
        data_m_access = 1'b1;
        @(posedge clk);
        #1;
        check("abort: access before reset", 32'(q_m_access), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        q_m_data_in = 16'hFFFF;
        #1;
        check("abort: access falls", 32'(q_m_access), 32'd0);
        check("abort: addr cleared", 32'(q_m_addr), 32'd0);
        check("abort: data_m_data_in quiet", 32'(data_m_data_in), 32'd0);
        check("abort: data_m_ack quiet", 32'(data_m_ack), 32'd0);
        exp_q.delete();
        push_txn(1'b1, 19'h03C3C, 1'b0, 2'b11, 16'h0000, 16'h7777);
        slave_lat = 1;
        base = done_cnt;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort: regrant on first clock", 32'(q_m_access), 32'd1);
        wait_done(base + 1, "abort: regrant done");
        repeat (3) @(posedge clk);

        // Stray ack while idle must reach nobody and leave the arbiter idle.
        slave_on = 1'b0;
        @(posedge clk);
        #2;
        q_m_data_in = 16'h1111;
        q_m_ack = 1'b1;
        #1;
        check("stray ack: instr_m_ack", 32'(instr_m_ack), 32'd0);
        check("stray ack: data_m_ack", 32'(data_m_ack), 32'd0);
        check("stray ack: access", 32'(q_m_access), 32'd0);
        @(posedge clk);
        #1;
        check("stray ack: still idle", 32'(q_m_access), 32'd0);
        q_m_ack = 1'b0;
        slave_on = 1'b1;
        apply(vecs[0]);

        check("final queue drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
